branch_hazard_ctrl: RTL
=======================

// Module: branch_hazard_ctrl
// PURPOSE
//  Sequences ID-stage branch/jump resolution. Owns the operand-forward selects of the
//  ID-stage target/compare unit, stalls ID/IF while a branch operand is an in-flight
//  load, and issues a one-cycle redirect + IF flush when the unit reports pc_sel=1.
//  Sits between decode, the ID-stage target/compare unit and the fetch PC register.
//  Counts branch statistics for perf CSRs.
// PARAMETERS
//  CNT_W      32  width of each saturating perf counter
//  EX_LD_STL  2   stall cycles when a branch source is a load in EX
//  MEM_LD_STL 1   stall cycles when a branch source is a load in MEM
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     async active-low reset
//  pipe_stall     in   1     global back-pressure; freezes FSM, counter and stats
//  id_valid       in   1     ID holds a real instruction
//  id_bj          in   1     ID instr is B, JAL or JALR
//  id_use_rs1/2   in   1     instr reads rs1 / rs2
//  id_rs1/id_rs2  in   5     source register indices
//  ex_rd/mem_rd/wb_rd  in 5  destination index per stage
//  ex_we/mem_we/wb_we  in 1  stage writes rd
//  ex_ld/mem_ld   in   1     stage holds a load
//  pc_sel         in   1     from target unit: branch taken or jump
//  pc_nxt         in   XLEN  from target unit: next PC
//  fwd_rs1/fwd_rs2 out id_fwd_sel_t  operand select to target unit
//  id_stall       out  1     hold IF and ID
//  if_flush       out  1     squash the instruction in IF
//  redir_vld      out  1     load redir_pc into fetch PC
//  redir_pc       out  XLEN  redirect target
//  cnt_bj/cnt_taken/cnt_stall  out CNT_W  B/J retired, taken, stall cycles
// BEHAVIOUR
//  Reset: state=RUN, stall counter=0, all stats=0, fwd_*=RS_ID_SEL, id_stall/if_flush/
//   redir_vld=0, redir_pc=0. Reset mid-stall abandons it; no redirect is issued.
//  Forward select (comb): per source, priority EX > MEM > WB > RS_ID_SEL when stage
//   we=1 and rd==rs!=0. rs==x0 always RS_ID_SEL.
//  Load hazard (comb): id_valid&id_bj&use&match against a stage with *_ld=1.
//   EX match -> need EX_LD_STL; MEM match -> MEM_LD_STL; both operands: max.
//  FSM states RUN, STALL:
//   RUN: hazard -> id_stall=1 this cycle, load cnt=need-1, go STALL (cnt=0 -> stay RUN,
//     re-evaluate next cycle). No hazard & id_valid & id_bj -> resolve: redir_vld=
//     if_flush=pc_sel, redir_pc=pc_nxt, cnt_bj++, cnt_taken+=pc_sel.
//   STALL: id_stall=1, cnt-- each cycle; at cnt==0 go RUN, re-check hazard there.
//  Hazard and pc_sel in the same cycle: hazard wins, no redirect, no stat update.
//  pipe_stall=1: state/cnt/stats hold; redir_vld=if_flush=0; id_stall follows FSM.
//  Redirect is combinational, same cycle as resolve; exactly one pulse per B/J.
//  Non-B/J instructions never stall or redirect here.
//  cnt_stall increments each cycle id_stall=1 & !pipe_stall. All counters saturate
//   at all-ones (no wrap).
//  redir_pc passes pc_nxt unmodified (JALR LSB already cleared upstream).
// STRUCTURE
//  defines pkg: bhc_state_t {RUN,STALL}; EX_LD_STL/MEM_LD_STL defaults;
//   reuse id_fwd_sel_t, data_t, XLEN.
//  Sub-module: sat_counter #(CNT_W) (clk,rst_n,en,q), instantiated 3x.
//  Forward/hazard logic as one always_comb; FSM as always_ff + always_comb next-state.
// TESTING
//  1 BEQ x1,x2, EX ALU writes x1 (ex_we=1,ex_ld=0), pc_sel=1, pc_nxt=0x100 ->
//    fwd_rs1=EX_ID_SEL, no stall, redir_vld=if_flush=1 one cycle, redir_pc=0x100.
//  2 BNE x3,x0, load x3 in EX -> id_stall=1 for 2 cycles, fwd_rs1=WB_ID_SEL... then
//    resolve; cnt_stall=2, cnt_bj=1.
//  3 JALR rs1=x5, load x5 in MEM, pc_sel=1 -> 1 stall cycle, then redirect; pc_sel
//    high during stall gives no redir_vld.
//  4 rs1 matches EX, MEM and WB (all we=1, no load) -> fwd_rs1=EX_ID_SEL; rs=x0
//    with ex_rd=0,ex_we=1 -> RS_ID_SEL.
//  5 pipe_stall=1 during STALL with cnt=1 -> cnt holds; release -> finishes; pipe_stall
//    at resolve -> redir_vld=0 until released, stats unchanged.
//  6 rst_n low mid-STALL -> all outputs reset async; force cnt_taken to all-ones,
//    taken branch -> stays all-ones.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and defaults for the ID-stage branch hazard controller.
// Also holds the forward-select priority picker used by the controller.
package branch_hazard_ctrl_pkg;

    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] data_t;

    typedef enum logic [1:0] {
        RS_ID_SEL  = 2'd0,
        EX_ID_SEL  = 2'd1,
        MEM_ID_SEL = 2'd2,
        WB_ID_SEL  = 2'd3
    } id_fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } bhc_state_t;

    localparam int EX_LD_STL_DEF  = 2;
    localparam int MEM_LD_STL_DEF = 1;

    // Youngest writer wins; x0 is never forwarded.
    function automatic id_fwd_sel_t fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        id_fwd_sel_t sel;
        sel = RS_ID_SEL;
        if (rs != 5'd0) begin
            if (ex_we && (ex_rd == rs))        sel = EX_ID_SEL;
            else if (mem_we && (mem_rd == rs)) sel = MEM_ID_SEL;
            else if (wb_we && (wb_rd == rs))   sel = WB_ID_SEL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Decode/pipeline/target-unit signals seen by the branch hazard controller.
// master = pipeline side driving the controller, slave = the controller.
interface branch_hazard_ctrl_if;
    import branch_hazard_ctrl_pkg::*;

    logic        pipe_stall;
    logic        id_valid;
    logic        id_bj;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        ex_we;
    logic        mem_we;
    logic        wb_we;
    logic        ex_ld;
    logic        mem_ld;
    logic        pc_sel;
    data_t       pc_nxt;
    id_fwd_sel_t fwd_rs1;
    id_fwd_sel_t fwd_rs2;
    logic        id_stall;
    logic        if_flush;
    logic        redir_vld;
    data_t       redir_pc;

    modport master (
        output pipe_stall, id_valid, id_bj, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, ex_ld, mem_ld, pc_sel, pc_nxt,
        input  fwd_rs1, fwd_rs2, id_stall, if_flush, redir_vld, redir_pc
    );

    modport slave (
        input  pipe_stall, id_valid, id_bj, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, ex_ld, mem_ld, pc_sel, pc_nxt,
        output fwd_rs1, fwd_rs2, id_stall, if_flush, redir_vld, redir_pc
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump sequencing: operand forward selects, load-use stalls,
// one-cycle redirect + IF flush on taken branches, and branch perf counters.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int EX_LD_STL  = EX_LD_STL_DEF,
    parameter int MEM_LD_STL = MEM_LD_STL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_hazard_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]     cnt_bj,
    output logic [CNT_W-1:0]     cnt_taken,
    output logic [CNT_W-1:0]     cnt_stall
);

    localparam int STL_MAX = (EX_LD_STL > MEM_LD_STL) ? EX_LD_STL : MEM_LD_STL;
    localparam int STL_W   = (STL_MAX < 2) ? 1 : $clog2(STL_MAX + 1);
    localparam logic [STL_W-1:0] EX_NEED  = STL_W'(EX_LD_STL);
    localparam logic [STL_W-1:0] MEM_NEED = STL_W'(MEM_LD_STL);

    id_fwd_sel_t      fwd1;
    id_fwd_sel_t      fwd2;
    logic [STL_W-1:0] need1;
    logic [STL_W-1:0] need2;
    logic [STL_W-1:0] need;
    logic             hazard;

    bhc_state_t       state;
    bhc_state_t       state_nxt;
    logic [STL_W-1:0] stl_cnt;
    logic [STL_W-1:0] stl_cnt_nxt;
    logic             stall_fsm;
    logic             resolve;

    logic             stall_out;
    logic             taken_go;
    logic             bj_en;
    logic             taken_en;
    logic             stall_en;

    always_comb begin
        fwd1  = fwd_pick(bus.id_rs1, bus.ex_rd, bus.ex_we, bus.mem_rd, bus.mem_we,
                         bus.wb_rd, bus.wb_we);
        fwd2  = fwd_pick(bus.id_rs2, bus.ex_rd, bus.ex_we, bus.mem_rd, bus.mem_we,
                         bus.wb_rd, bus.wb_we);
        need1 = '0;
        need2 = '0;
        // A load only hurts if it is the youngest producer of the operand.
        if (bus.id_valid && bus.id_bj && bus.id_use_rs1) begin
            if ((fwd1 == EX_ID_SEL) && bus.ex_ld)        need1 = EX_NEED;
            else if ((fwd1 == MEM_ID_SEL) && bus.mem_ld) need1 = MEM_NEED;
        end
        if (bus.id_valid && bus.id_bj && bus.id_use_rs2) begin
            if ((fwd2 == EX_ID_SEL) && bus.ex_ld)        need2 = EX_NEED;
            else if ((fwd2 == MEM_ID_SEL) && bus.mem_ld) need2 = MEM_NEED;
        end
        need   = (need1 > need2) ? need1 : need2;
        hazard = (need != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            stl_cnt <= '0;
        end else if (!bus.pipe_stall) begin
            state   <= state_nxt;
            stl_cnt <= stl_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stl_cnt_nxt = stl_cnt;
        stall_fsm   = 1'b0;
        resolve     = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    stall_fsm   = 1'b1;
                    stl_cnt_nxt = need - STL_W'(1);
                    if (need != STL_W'(1)) state_nxt = STALL;
                end else if (bus.id_valid && bus.id_bj) begin
                    resolve = 1'b1;
                end
            end
            STALL: begin
                stall_fsm = 1'b1;
                // Hazard is re-evaluated in RUN once the count drains.
                if (stl_cnt <= STL_W'(1)) begin
                    stl_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    stl_cnt_nxt = stl_cnt - STL_W'(1);
                end
            end
            default: begin
                state_nxt   = RUN;
                stl_cnt_nxt = '0;
            end
        endcase
    end

    // Combinational outputs are gated so reset forces them idle immediately.
    assign stall_out     = rst_n & stall_fsm;
    assign taken_go      = rst_n & resolve & bus.pc_sel & ~bus.pipe_stall;
    assign bus.fwd_rs1   = rst_n ? fwd1 : RS_ID_SEL;
    assign bus.fwd_rs2   = rst_n ? fwd2 : RS_ID_SEL;
    assign bus.id_stall  = stall_out;
    assign bus.if_flush  = taken_go;
    assign bus.redir_vld = taken_go;
    assign bus.redir_pc  = taken_go ? bus.pc_nxt : '0;

    assign bj_en    = resolve & ~bus.pipe_stall;
    assign taken_en = bj_en & bus.pc_sel;
    assign stall_en = stall_out & ~bus.pipe_stall;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_bj (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bj_en),
        .q     (cnt_bj)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (taken_en),
        .q     (cnt_taken)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .q     (cnt_stall)
    );

endmodule
